sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single request port of the SDRAM controller between three masters.
- Port 0 is video/shifter (highest priority). Port 1 is the CPU. Port 2 is DMA/floppy/ROM loader.
- Sits between the system logic and the SDRAM controller, inside the clk32 domain, in front of the SDRAM pins.
- Serialises accesses, issues exactly one controller transaction at a time, returns read data and a completion pulse to the winning port, and guards against a hung controller with a timeout.

Parameters:
- AW, 22, word address width of every port and of the controller.
- DW, 16, data width.
- STARVE_MAX, 4, consecutive port-0 grants allowed while port 1 or 2 is waiting before the waiting low port is forced.
- TIMEOUT, 63, clk32 cycles to wait for sd_ack before aborting (range 1..255).

Ports:
- clk32  in  1  system clock, 32 MHz.
- reset_n  in  1  asynchronous active-low reset.
- req  in  3  per-port request level; held high until ack.
- we  in  3  per-port write enable (1 = write).
- addr0, addr1, addr2  in  AW each  per-port word address.
- din0, din1, din2  in  DW each  per-port write data.
- ds0, ds1, ds2  in  2 each  per-port byte strobes {upper, lower}, active high.
- ack  out  3  one-cycle completion pulse per port.
- err  out  3  one-cycle timeout pulse per port, coincident with ack.
- dout  out  DW  read data, valid on the ack cycle; held afterwards.
- sd_req  out  1  one-cycle request pulse to the controller.
- sd_we  out  1  write enable to the controller.
- sd_addr  out  AW  address to the controller.
- sd_din  out  DW  write data to the controller.
- sd_ds  out  2  byte strobes to the controller.
- sd_ack  in  1  controller completion pulse; sd_dout is valid in the same cycle.
- sd_dout  in  DW  controller read data.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset (async assert, sync deassert in the upstream reset logic):
  - ack, err, sd_req, sd_we, busy = 0; sd_ds = 2'b00; sd_addr, sd_din, dout = 0.
  - State = IDLE; round-robin pointer rr = port 1; starve counter = 0; timeout counter = 0.
- States:
  - IDLE:
    - Evaluate req. If any bit is set, select a winner and latch its we/addr/din/ds into the sd_* registers.
    - Assert sd_req for exactly one cycle, set busy, go to WAIT.
    - Arbitration to sd_req latency is 1 cycle: req high at edge N gives sd_req high after edge N+1.
  - WAIT:
    - sd_req = 0; the timeout counter increments each cycle.
    - On sd_ack: latch sd_dout into dout (reads only; writes leave dout unchanged), pulse ack[winner] for one cycle, go to DONE.
    - If the counter reaches TIMEOUT with no sd_ack: pulse ack[winner] and err[winner] together, leave dout unchanged, go to DONE.
  - DONE:
    - One cycle; busy drops and the state returns to IDLE.
    - This is the cycle in which the requester lowers req. Req sampled in DONE is ignored, so one port cannot be granted twice from a stale level.
    - Minimum spacing between two sd_req pulses is 4 cycles (IDLE, WAIT with immediate ack, DONE, IDLE).
- Winner selection:
  - Default: port 0 if req[0]; else the rr-preferred one of ports 1 and 2 if requesting; else the other one.
  - Starvation: when a port-0 grant happens while req[1] or req[2] is high, starve counter +1; any port-1/2 grant clears it.
  - If starve counter = STARVE_MAX and req[1] or req[2] is high, a low port wins (rr order) even if req[0] is high.
  - rr toggles to the other low port after each port-1/2 grant. Port-0 grants do not touch rr.
- Fields are sampled only at grant. Changes to addr/din/we/ds during WAIT are ignored.
- A req that drops before grant is simply not served; no ack is produced.
- sd_ack arriving in IDLE or DONE (spurious): ignored, no ack output, dout unchanged.
- A late sd_ack after a timeout abort is treated as spurious.
- Reset asserted mid-WAIT: everything returns to reset values immediately and no ack is issued. The controller is expected to be reset by the same reset_n.
- ack and err are never asserted for more than one port in the same cycle.

Test Plan:
- Single read on port 1 (addr1=22'h00_1234, we=0), controller acks 5 cycles after sd_req with sd_dout=16'hBEEF:
  - sd_req pulses once with sd_addr=22'h001234, sd_we=0.
  - ack=3'b010 for one cycle with dout=16'hBEEF; busy high from the cycle after grant through WAIT.
- Simultaneous req=3'b111, controller acks immediately:
  - grant order is 0,1,0,2,0,1.
  - With port 0 held continuously, port 1 or 2 is forced after at most 4 consecutive port-0 grants.
- Port 2 write, din2=16'hA55A, ds2=2'b01, addr2 changed during WAIT:
  - sd_din=16'hA55A, sd_ds=2'b01, sd_addr keeps the value latched at grant; dout unchanged after ack.
- Controller never acks on a port 0 read:
  - exactly TIMEOUT=63 cycles after sd_req, ack[0] and err[0] pulse together; the arbiter returns to IDLE and serves the pending port-1 request next.
- Spurious sd_ack while idle, then reset_n pulsed low during WAIT:
  - no ack on the spurious pulse.
  - On reset, all outputs go to 0 asynchronously (before the next clk32 edge) and no ack appears after release until a new req.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single request port of the SDRAM controller between three
//   masters in the clk32 domain. Port 0 (video/shifter) has priority, ports 1
//   (CPU) and 2 (DMA/floppy/ROM loader) alternate round-robin, and a starve
//   counter forces a low port through after STARVE_MAX back-to-back port-0
//   grants. One controller transaction is outstanding at a time; a timeout
//   aborts a transaction the controller never acknowledges.
//
// Ports
//   clk32, reset_n        clock, asynchronous active-low reset
//   req/we [2:0]          per-port request level and write enable
//   addrN/dinN/dsN        per-port word address, write data, byte strobes
//   ack/err [2:0]         one-cycle completion / timeout pulse to the winner
//   dout                  read data, valid on the ack cycle and held after
//   sd_req/we/addr/din/ds request pulse and fields to the controller
//   sd_ack/sd_dout        controller completion pulse and read data
//   busy                  high while a transaction is outstanding
module sdram_port_arbiter #(
    parameter int AW         = 22,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic          clk32,
    input  logic          reset_n,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [1:0]    ds0,
    input  logic [1:0]    ds1,
    input  logic [1:0]    ds2,
    output logic [2:0]    ack,
    output logic [2:0]    err,
    output logic [DW-1:0] dout,
    output logic          sd_req,
    output logic          sd_we,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_din,
    output logic [1:0]    sd_ds,
    input  logic          sd_ack,
    input  logic [DW-1:0] sd_dout,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    win;         // combinational winner in IDLE
    logic [1:0]    win_q;       // winner of the outstanding transaction
    logic          rr_p2;       // 1: port 2 preferred among the low ports
    logic [SW-1:0] starve_cnt;
    logic [7:0]    tmo_cnt;
    logic          low_req;
    logic          force_low;
    logic          grant;
    logic          tmo_hit;
    logic [2:0]    ack_nxt;
    logic [2:0]    err_nxt;

    function automatic logic [2:0] port_mask(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    // Arbitration: port 0 first unless the starve limit forces a low port.
    always_comb begin
        low_req   = req[1] | req[2];
        force_low = low_req && (starve_cnt == SW'(STARVE_MAX));
        win       = 2'd0;
        if (!req[0] || force_low) begin
            if (rr_p2) win = req[2] ? 2'd2 : 2'd1;
            else       win = req[1] ? 2'd1 : 2'd2;
        end
        grant   = (state == IDLE) && (req != 3'b000);
        tmo_hit = (state == WAIT) && !sd_ack && (tmo_cnt == 8'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; DONE always burns one cycle so a stale req level
    // from the port just served cannot win again.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 3'b000) state_nxt = WAIT;
            WAIT:    if (sd_ack || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion pulses for the outstanding winner
    always_comb begin
        ack_nxt = 3'b000;
        err_nxt = 3'b000;
        if (state == WAIT && (sd_ack || tmo_hit)) ack_nxt = port_mask(win_q);
        if (tmo_hit) err_nxt = port_mask(win_q);
    end

    // Registered outputs, latched request fields and arbitration state
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            ack        <= 3'b000;
            err        <= 3'b000;
            sd_req     <= 1'b0;
            sd_we      <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= '0;
            sd_ds      <= 2'b00;
            dout       <= '0;
            busy       <= 1'b0;
            win_q      <= 2'd0;
            rr_p2      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            sd_req <= grant;
            ack    <= ack_nxt;
            err    <= err_nxt;
            if (grant) begin
                win_q   <= win;
                busy    <= 1'b1;
                tmo_cnt <= '0;
                case (win)
                    2'd1: begin
                        sd_we <= we[1]; sd_addr <= addr1; sd_din <= din1; sd_ds <= ds1;
                    end
                    2'd2: begin
                        sd_we <= we[2]; sd_addr <= addr2; sd_din <= din2; sd_ds <= ds2;
                    end
                    default: begin
                        sd_we <= we[0]; sd_addr <= addr0; sd_din <= din0; sd_ds <= ds0;
                    end
                endcase
                if (win == 2'd0) begin
                    if (low_req && starve_cnt != SW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + SW'(1);
                end else begin
                    starve_cnt <= '0;
                    rr_p2      <= (win == 2'd1);
                end
            end
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (sd_ack && !sd_we) dout <= sd_dout;
                if (sd_ack || tmo_hit) busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter: a small request master per port,
//   a controller model with programmable ack delay, and an event log that the
//   directed sequence checks against hand-computed values.
module tb_sdram_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;

    logic          clk32;
    logic          reset_n;
    logic [2:0]    req, we;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] din0, din1, din2;
    logic [1:0]    ds0, ds1, ds2;
    logic [2:0]    ack, err;
    logic [DW-1:0] dout;
    logic          sd_req, sd_we;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_din;
    logic [1:0]    sd_ds;
    logic          sd_ack;
    logic [DW-1:0] sd_dout;
    logic          busy;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(63)) dut (
        .clk32(clk32), .reset_n(reset_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .din0(din0), .din1(din1), .din2(din2),
        .ds0(ds0), .ds1(ds1), .ds2(ds2),
        .ack(ack), .err(err), .dout(dout),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din), .sd_ds(sd_ds),
        .sd_ack(sd_ack), .sd_dout(sd_dout), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int bad_pulse = 0;

    // control knobs owned by the main sequence
    logic [2:0]    want, hold, rearm;
    logic          ctl_en, spur_go;
    int            ctl_delay;
    logic [DW-1:0] ctl_data;

    // event logs owned by the monitor
    logic [2:0]    ack_raw_q[$];
    logic [2:0]    ack_err_q[$];
    logic [DW-1:0] ack_dout_q[$];
    logic [AW-1:0] ack_addr_q[$];
    logic          ack_busy_q[$];
    int            ack_cyc_q[$];
    logic [AW-1:0] req_addr_q[$];
    logic [DW-1:0] req_din_q[$];
    logic [1:0]    req_ds_q[$];
    logic          req_we_q[$];
    logic          req_busy_q[$];
    int            req_cyc_q[$];

    int ab, rb;

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    initial forever begin
        @(posedge clk32);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Request masters: raise on want, drop on ack unless held, optionally re-raise.
    initial begin
        int rc[3];
        logic [2:0] wprev;
        req = 3'b000;
        wprev = 3'b000;
        rc = '{0, 0, 0};
        forever begin
            @(negedge clk32);
            for (int i = 0; i < 3; i++) begin
                if (!want[i]) begin
                    req[i] = 1'b0;
                    rc[i] = 0;
                end else if (!wprev[i]) begin
                    req[i] = 1'b1;
                end else if (rc[i] > 0) begin
                    rc[i]--;
                    if (rc[i] == 0) req[i] = 1'b1;
                end
                if (ack[i] && !hold[i]) begin
                    req[i] = 1'b0;
                    if (rearm[i]) rc[i] = 2;
                end
            end
            wprev = want;
        end
    end

    // Controller model: sd_ack ctl_delay cycles after the sd_req cycle.
    initial begin
        logic spur_prev;
        spur_prev = 1'b0;
        sd_ack = 1'b0;
        sd_dout = '0;
        forever begin
            @(posedge clk32);
            #1;
            if (spur_go && !spur_prev) begin
                sd_dout = 16'hDEAD;
                sd_ack = 1'b1;
                @(posedge clk32);
                #1;
                sd_ack = 1'b0;
            end else if (ctl_en && sd_req && reset_n) begin
                repeat (ctl_delay) @(posedge clk32);
                #1;
                sd_ack = 1'b1;
                sd_dout = ctl_data;
                @(posedge clk32);
                #1;
                sd_ack = 1'b0;
            end
            spur_prev = spur_go;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk32);
        if (reset_n) begin
            if (sd_req) begin
                req_addr_q.push_back(sd_addr);
                req_din_q.push_back(sd_din);
                req_ds_q.push_back(sd_ds);
                req_we_q.push_back(sd_we);
                req_busy_q.push_back(busy);
                req_cyc_q.push_back(cyc);
            end
            if (ack != 3'b000) begin
                ack_raw_q.push_back(ack);
                ack_err_q.push_back(err);
                ack_dout_q.push_back(dout);
                ack_addr_q.push_back(sd_addr);
                ack_busy_q.push_back(busy);
                ack_cyc_q.push_back(cyc);
            end
            if ((ack != 3'b000 && !$onehot(ack)) || (err & ~ack) != 3'b000) bad_pulse++;
        end
    end

    task automatic wait_acks(input int n, input int limit, input string tag);
        int k = 0;
        while (ack_raw_q.size() < ab + n && k < limit) begin
            @(negedge clk32);
            #1;
            k++;
        end
        check(tag, 32'(ack_raw_q.size() >= ab + n), 32'd1);
    endtask

    task automatic wait_reqs(input int n, input int limit, input string tag);
        int k = 0;
        while (req_cyc_q.size() < rb + n && k < limit) begin
            @(negedge clk32);
            #1;
            k++;
        end
        check(tag, 32'(req_cyc_q.size() >= rb + n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        int quiet = 0;
        while (quiet < 3 && k < 200) begin
            @(negedge clk32);
            #1;
            k++;
            if (!busy && req == 3'b000) quiet++;
            else quiet = 0;
        end
        check(tag, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic do_reset();
        want = 3'b000; hold = 3'b000; rearm = 3'b000; ctl_en = 1'b0;
        repeat (2) @(negedge clk32);
        reset_n = 1'b0;
        repeat (2) @(posedge clk32);
        #2 reset_n = 1'b1;
        ab = ack_raw_q.size();
        rb = req_cyc_q.size();
    endtask

    initial begin
        logic [2:0] exp_rr [6];
        logic [2:0] exp_st [5];
        exp_rr = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
        exp_st = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
        reset_n = 1'b0;
        want = 3'b000; hold = 3'b000; rearm = 3'b000;
        we = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0;
        din0 = '0; din1 = '0; din2 = '0;
        ds0 = 2'b00; ds1 = 2'b00; ds2 = 2'b00;
        ctl_en = 1'b0; spur_go = 1'b0; ctl_delay = 1; ctl_data = '0;
        ab = 0; rb = 0;

        // reset state
        repeat (2) @(posedge clk32);
        #2;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_sd_req", 32'(sd_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sd_we", 32'(sd_we), 32'h0);
        check("rst_sd_ds", 32'(sd_ds), 32'h0);
        check("rst_sd_addr", 32'(sd_addr), 32'h0);
        check("rst_sd_din", 32'(sd_din), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        #1 reset_n = 1'b1;

        // single read on port 1, controller acks 5 cycles after sd_req
        ctl_en = 1'b1; ctl_delay = 5; ctl_data = 16'hBEEF;
        addr1 = 22'h001234; we[1] = 1'b0;
        want[1] = 1'b1;
        wait_acks(1, 60, "rd1_wait");
        repeat (4) @(negedge clk32);
        #1;
        check("rd1_nreq", 32'(req_cyc_q.size() - rb), 32'd1);
        check("rd1_nack", 32'(ack_raw_q.size() - ab), 32'd1);
        if (ack_raw_q.size() > ab && req_cyc_q.size() > rb) begin
            check("rd1_sd_addr", 32'(req_addr_q[rb]), 32'h001234);
            check("rd1_sd_we", 32'(req_we_q[rb]), 32'h0);
            check("rd1_busy_wait", 32'(req_busy_q[rb]), 32'h1);
            check("rd1_ack", 32'(ack_raw_q[ab]), 32'h2);
            check("rd1_err", 32'(ack_err_q[ab]), 32'h0);
            check("rd1_dout", 32'(ack_dout_q[ab]), 32'hBEEF);
            check("rd1_busy_done", 32'(ack_busy_q[ab]), 32'h0);
            check("rd1_latency", 32'(ack_cyc_q[ab] - req_cyc_q[rb]), 32'd6);
        end
        want[1] = 1'b0;
        repeat (2) @(negedge clk32);

        // port 2 write, fields changed during WAIT, dout must keep BEEF
        ab = ack_raw_q.size(); rb = req_cyc_q.size();
        ctl_data = 16'h1111;
        we[2] = 1'b1; din2 = 16'hA55A; ds2 = 2'b01; addr2 = 22'h2AAAAA;
        want[2] = 1'b1;
        wait_reqs(1, 20, "wr2_req_wait");
        addr2 = 22'h155555; din2 = 16'h0000; ds2 = 2'b10; we[2] = 1'b0;
        wait_acks(1, 60, "wr2_wait");
        if (ack_raw_q.size() > ab && req_cyc_q.size() > rb) begin
            check("wr2_sd_din", 32'(req_din_q[rb]), 32'hA55A);
            check("wr2_sd_ds", 32'(req_ds_q[rb]), 32'h1);
            check("wr2_sd_we", 32'(req_we_q[rb]), 32'h1);
            check("wr2_sd_addr", 32'(req_addr_q[rb]), 32'h2AAAAA);
            check("wr2_addr_at_ack", 32'(ack_addr_q[ab]), 32'h2AAAAA);
            check("wr2_ack", 32'(ack_raw_q[ab]), 32'h4);
            check("wr2_dout_kept", 32'(ack_dout_q[ab]), 32'hBEEF);
        end
        want[2] = 1'b0;
        wait_idle("wr2_idle");

        // all three requesting, immediate acks, masters re-request
        do_reset();
        we = 3'b000; ctl_en = 1'b1; ctl_delay = 1; ctl_data = 16'h0F0F;
        rearm = 3'b111;
        want = 3'b111;
        wait_acks(6, 200, "rr_wait");
        want = 3'b000;
        rearm = 3'b000;
        wait_idle("rr_idle");
        for (int i = 0; i < 6; i++)
            if (ack_raw_q.size() > ab + i)
                check($sformatf("rr_order%0d", i), 32'(ack_raw_q[ab + i]), 32'(exp_rr[i]));
        if (req_cyc_q.size() > rb + 1)
            check("rr_spacing", 32'(req_cyc_q[rb + 1] - req_cyc_q[rb]), 32'd4);

        // port 0 held continuously against port 1
        do_reset();
        ctl_en = 1'b1; ctl_delay = 1;
        hold = 3'b001;
        want = 3'b011;
        wait_acks(5, 200, "st_wait");
        want = 3'b000;
        hold = 3'b000;
        wait_idle("st_idle");
        for (int i = 0; i < 5; i++)
            if (ack_raw_q.size() > ab + i)
                check($sformatf("st_order%0d", i), 32'(ack_raw_q[ab + i]), 32'(exp_st[i]));

        // controller never acks a port 0 read; port 1 pending behind it
        do_reset();
        ctl_en = 1'b0; ctl_data = 16'h5A5A; ctl_delay = 1;
        addr0 = 22'h3F0000; addr1 = 22'h000777;
        want[0] = 1'b1;
        wait_reqs(1, 20, "to_req_wait");
        want[1] = 1'b1;
        wait_acks(1, 100, "to_wait");
        ctl_en = 1'b1;
        if (ack_raw_q.size() > ab && req_cyc_q.size() > rb) begin
            check("to_ack", 32'(ack_raw_q[ab]), 32'h1);
            check("to_err", 32'(ack_err_q[ab]), 32'h1);
            check("to_latency", 32'(ack_cyc_q[ab] - req_cyc_q[rb]), 32'd63);
            check("to_dout_kept", 32'(ack_dout_q[ab]), 32'h0);
        end
        wait_acks(2, 40, "to_next_wait");
        if (ack_raw_q.size() > ab + 1 && req_cyc_q.size() > rb + 1) begin
            check("to_next_ack", 32'(ack_raw_q[ab + 1]), 32'h2);
            check("to_next_err", 32'(ack_err_q[ab + 1]), 32'h0);
            check("to_next_addr", 32'(req_addr_q[rb + 1]), 32'h000777);
            check("to_next_dout", 32'(ack_dout_q[ab + 1]), 32'h5A5A);
        end
        want = 3'b000;
        wait_idle("to_idle");

        // spurious sd_ack while idle, then reset during WAIT
        do_reset();
        spur_go = 1'b1;
        repeat (4) @(negedge clk32);
        spur_go = 1'b0;
        #1;
        check("spur_nack", 32'(ack_raw_q.size() - ab), 32'd0);
        check("spur_dout", 32'(dout), 32'h0);
        addr1 = 22'h0ABCDE;
        want[1] = 1'b1;
        wait_reqs(1, 20, "mr_req_wait");
        repeat (5) @(posedge clk32);
        #2;
        check("mr_busy_before", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_sd_addr", 32'(sd_addr), 32'h0);
        check("mr_sd_req", 32'(sd_req), 32'h0);
        check("mr_ack", 32'(ack | err), 32'h0);
        want = 3'b000;
        repeat (2) @(negedge clk32);
        @(posedge clk32);
        #2 reset_n = 1'b1;
        repeat (80) @(posedge clk32);
        #2;
        check("mr_no_ack", 32'(ack_raw_q.size() - ab), 32'd0);
        check("mr_idle_busy", 32'(busy), 32'h0);

        check("pulse_shape", 32'(bad_pulse), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
